// File: rtl/tug_pkg.sv
// -----------------------------------------------------------------------------
// tug_pkg
// Shared definitions for the tug-of-war match scorekeeper:
//   - tug_state_t   : match FSM states (PLAY / HOLD / CLEAR / DONE)
//   - SEG_BLANK     : active-low pattern with every segment off
//   - SEG_DIGITS    : active-low DE1 seven-segment patterns for digits 0..9
// -----------------------------------------------------------------------------
package tug_pkg;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    HOLD  = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } tug_state_t;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_DIGITS [10] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

endpackage

// File: rtl/seg7_digit.sv
// -----------------------------------------------------------------------------
// seg7_digit
// Combinational decode of a 4-bit value to active-low seven-segment lines.
// Values above 9 produce a blank digit.
//   i_value : input  [3:0] value to display
//   o_seg   : output [6:0] active-low segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module seg7_digit
  import tug_pkg::*;
(
  input  logic [3:0] i_value,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (i_value <= 4'd9) begin
      o_seg = SEG_DIGITS[i_value];
    end
  end

endmodule

// File: rtl/tug_score_keeper.sv
// -----------------------------------------------------------------------------
// tug_score_keeper
// Match scorekeeper downstream of the tug-of-war playfield. Counts round wins
// per player from the end-light levels, holds the winning light for
// HOLD_CYCLES, then pulses roundReset for one cycle to clear the playfield.
// Freezes the match once either player reaches WIN_SCORE.
//
// Parameters:
//   WIN_SCORE   : round wins needed to take the match (1..9)
//   HOLD_CYCLES : cycles the winning light stays lit before restart (>= 1)
// Ports:
//   clk        : system clock
//   reset      : synchronous, active-low; clears scores and FSM
//   leftWins   : level, leftmost end light lit
//   rightWins  : level, rightmost end light lit
//   roundReset : one-cycle active-high playfield restart pulse
//   leftScore  : left player's round wins
//   rightScore : right player's round wins
//   matchOver  : high once either score equals WIN_SCORE
//   leftChamp  : high with matchOver when the left player won
//   hexLeft    : active-low segments of leftScore (HEX5)
//   hexRight   : active-low segments of rightScore (HEX0)
// -----------------------------------------------------------------------------
module tug_score_keeper
  import tug_pkg::*;
#(
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       leftWins,
  input  logic       rightWins,
  output logic       roundReset,
  output logic [3:0] leftScore,
  output logic [3:0] rightScore,
  output logic       matchOver,
  output logic       leftChamp,
  output logic [6:0] hexLeft,
  output logic [6:0] hexRight
);

  localparam int         CNT_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [3:0] WIN_VAL  = 4'(WIN_SCORE);

  tug_state_t       r_state;
  logic [3:0]       r_left_score;
  logic [3:0]       r_right_score;
  logic [CNT_W-1:0] r_cnt;
  logic             r_round_reset;
  logic             r_match_over;
  logic             r_left_champ;

  tug_state_t       w_state_next;
  logic [3:0]       w_left_next;
  logic [3:0]       w_right_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_round_reset_next;
  logic             w_match_over_next;
  logic             w_left_champ_next;

  // Next-state logic
  always_comb begin
    w_state_next       = r_state;
    w_left_next        = r_left_score;
    w_right_next       = r_right_score;
    w_cnt_next         = r_cnt;
    w_round_reset_next = 1'b0;

    case (r_state)
      PLAY: begin
        if (leftWins && rightWins) begin
          // Tie: no point, but the playfield still needs its restart.
          w_cnt_next   = CNT_LOAD;
          w_state_next = HOLD;
        end else if (leftWins) begin
          w_left_next = r_left_score + 4'd1;
          if (w_left_next == WIN_VAL) begin
            w_state_next = DONE;
          end else begin
            w_cnt_next   = CNT_LOAD;
            w_state_next = HOLD;
          end
        end else if (rightWins) begin
          w_right_next = r_right_score + 4'd1;
          if (w_right_next == WIN_VAL) begin
            w_state_next = DONE;
          end else begin
            w_cnt_next   = CNT_LOAD;
            w_state_next = HOLD;
          end
        end
      end

      HOLD: begin
        // Loaded with HOLD_CYCLES-1 so the pulse lands HOLD_CYCLES edges
        // after the scoring edge.
        if (r_cnt == '0) begin
          w_round_reset_next = 1'b1;
          w_state_next       = CLEAR;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end

      // Lights are still being cleared by the pulse; ignore them one cycle.
      CLEAR: w_state_next = PLAY;

      DONE: w_state_next = DONE;

      default: w_state_next = PLAY;
    endcase

    w_match_over_next = (w_state_next == DONE);
    w_left_champ_next = w_match_over_next && (w_left_next == WIN_VAL);
  end

  // All state, including the registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= PLAY;
      r_left_score  <= 4'd0;
      r_right_score <= 4'd0;
      r_cnt         <= '0;
      r_round_reset <= 1'b0;
      r_match_over  <= 1'b0;
      r_left_champ  <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_left_score  <= w_left_next;
      r_right_score <= w_right_next;
      r_cnt         <= w_cnt_next;
      r_round_reset <= w_round_reset_next;
      r_match_over  <= w_match_over_next;
      r_left_champ  <= w_left_champ_next;
    end
  end

  assign roundReset = r_round_reset;
  assign leftScore  = r_left_score;
  assign rightScore = r_right_score;
  assign matchOver  = r_match_over;
  assign leftChamp  = r_left_champ;

  seg7_digit u_seg_left (
    .i_value (r_left_score),
    .o_seg   (hexLeft)
  );

  seg7_digit u_seg_right (
    .i_value (r_right_score),
    .o_seg   (hexRight)
  );

endmodule

// File: tb/tb_tug_score_keeper.sv
// -----------------------------------------------------------------------------
// tb_tug_score_keeper
// Directed bench for tug_score_keeper with WIN_SCORE=3, HOLD_CYCLES=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_tug_score_keeper;

  logic       clk;
  logic       reset;
  logic       leftWins;
  logic       rightWins;
  logic       roundReset;
  logic [3:0] leftScore;
  logic [3:0] rightScore;
  logic       matchOver;
  logic       leftChamp;
  logic [6:0] hexLeft;
  logic [6:0] hexRight;

  int checks = 0;
  int errors = 0;

  tug_score_keeper #(
    .WIN_SCORE   (3),
    .HOLD_CYCLES (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .leftWins   (leftWins),
    .rightWins  (rightWins),
    .roundReset (roundReset),
    .leftScore  (leftScore),
    .rightScore (rightScore),
    .matchOver  (matchOver),
    .leftChamp  (leftChamp),
    .hexLeft    (hexLeft),
    .hexRight   (hexRight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Called right after the scoring edge N: pulse must appear only after N+4,
  // and be gone after N+5 (CLEAR -> PLAY).
  task automatic hold_and_clear(input string tag);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk({tag, " rr_hold"}, {7'd0, roundReset}, 8'd0);
    end
    tick();
    chk({tag, " rr_pulse"}, {7'd0, roundReset}, 8'd1);
    tick();
    chk({tag, " rr_clear"}, {7'd0, roundReset}, 8'd0);
  endtask

  initial begin
    reset     = 1'b0;
    leftWins  = 1'b0;
    rightWins = 1'b0;

    // 1. Reset held two cycles
    tick();
    tick();
    chk("rst leftScore",  {4'd0, leftScore},  8'd0);
    chk("rst rightScore", {4'd0, rightScore}, 8'd0);
    chk("rst matchOver",  {7'd0, matchOver},  8'd0);
    chk("rst roundReset", {7'd0, roundReset}, 8'd0);
    chk("rst hexLeft",    {1'b0, hexLeft},    8'b01000000);
    chk("rst hexRight",   {1'b0, hexRight},   8'b01000000);
    $display("reset: scores %0d/%0d", leftScore, rightScore);
    reset = 1'b1;

    // Idle through edge 9
    for (int k = 3; k <= 9; k++) begin
      tick();
    end
    chk("idle leftScore", {4'd0, leftScore}, 8'd0);

    // 2. Left win, level held through HOLD and CLEAR
    leftWins = 1'b1;
    tick();  // edge 10
    chk("lw leftScore",  {4'd0, leftScore},  8'd1);
    chk("lw roundReset", {7'd0, roundReset}, 8'd0);
    chk("lw hexLeft",    {1'b0, hexLeft},    8'b01111001);
    hold_and_clear("lw");
    chk("lw held score", {4'd0, leftScore}, 8'd1);
    leftWins = 1'b0;
    tick();
    chk("lw after clear", {4'd0, leftScore}, 8'd1);
    $display("left round: scores %0d/%0d", leftScore, rightScore);

    // 3. Tie
    leftWins  = 1'b1;
    rightWins = 1'b1;
    tick();
    leftWins  = 1'b0;
    rightWins = 1'b0;
    chk("tie leftScore",  {4'd0, leftScore},  8'd1);
    chk("tie rightScore", {4'd0, rightScore}, 8'd0);
    hold_and_clear("tie");
    $display("tie round: scores %0d/%0d", leftScore, rightScore);

    // 4. Right takes three rounds
    for (int r = 1; r <= 3; r++) begin
      rightWins = 1'b1;
      tick();
      rightWins = 1'b0;
      chk("rw rightScore", {4'd0, rightScore}, 8'(r));
      $display("right round %0d: scores %0d/%0d", r, leftScore, rightScore);
      if (r < 3) hold_and_clear("rw");
    end
    chk("rw matchOver", {7'd0, matchOver}, 8'd1);
    chk("rw leftChamp", {7'd0, leftChamp}, 8'd0);
    chk("rw hexRight",  {1'b0, hexRight},  8'b00110000);
    leftWins  = 1'b1;
    rightWins = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("done roundReset", {7'd0, roundReset}, 8'd0);
      chk("done scores",     {leftScore, rightScore}, 8'h13);
      chk("done matchOver",  {7'd0, matchOver}, 8'd1);
    end
    leftWins  = 1'b0;
    rightWins = 1'b0;

    // 5. Reset during the second HOLD cycle
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rst2 matchOver", {7'd0, matchOver}, 8'd0);
    leftWins = 1'b1;
    tick();  // scoring edge N
    leftWins = 1'b0;
    chk("midhold score", {4'd0, leftScore}, 8'd1);
    tick();  // edge N+1: second HOLD cycle begins
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("midhold rst leftScore", {4'd0, leftScore}, 8'd0);
    chk("midhold rst roundReset", {7'd0, roundReset}, 8'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("midhold no pulse", {7'd0, roundReset}, 8'd0);
    end
    $display("mid-hold reset: scores %0d/%0d", leftScore, rightScore);

    // 6. Walk leftScore 0..3 (also proves the FSM restarted in PLAY)
    chk("walk hex0", {1'b0, hexLeft}, 8'b01000000);
    for (int r = 1; r <= 3; r++) begin
      leftWins = 1'b1;
      tick();
      leftWins = 1'b0;
      chk("walk leftScore", {4'd0, leftScore}, 8'(r));
      case (r)
        1: chk("walk hex1", {1'b0, hexLeft}, 8'b01111001);
        2: chk("walk hex2", {1'b0, hexLeft}, 8'b00100100);
        default: chk("walk hex3", {1'b0, hexLeft}, 8'b00110000);
      endcase
      $display("left walk %0d: hexLeft=%b", r, hexLeft);
      if (r < 3) hold_and_clear("walk");
    end
    chk("walk matchOver", {7'd0, matchOver}, 8'd1);
    chk("walk leftChamp", {7'd0, leftChamp}, 8'd1);
    tick();
    chk("walk no pulse", {7'd0, roundReset}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
